// File: rtl/mem_stage_access_pkg.sv
// Shared pipeline definitions for the MEM stage: access FSM states and the
// MEM/WB control bundle.
package mem_stage_access_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Data travels beside this bundle so each instance can size it freely.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] wb_addr;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_access.sv
// MEM stage: consumes EX/MEM requests, drives a single-port low-active data
// SRAM with fixed read latency and produces the registered MEM/WB bundle.
module mem_stage_access #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = mem_stage_access_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              mem_read_n_i,
    input  logic              mem_write_n_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic [4:0]        wb_addr_i,
    output logic              stall_o,
    output logic              sram_cs_n_o,
    output logic              sram_we_n_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              wb_valid_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic [4:0]        wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o
);

    import mem_stage_access_pkg::*;

    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       req_addr_r;
    mem_wb_t           req_ctrl_r;
    logic              req_store_r;
    logic              stall_s;

    logic              sram_cs_n_r;
    logic              sram_we_n_r;
    logic [ADDR_W-1:0] sram_addr_r;
    logic [DATA_W-1:0] sram_wdata_r;
    logic              wb_valid_r;
    logic              reg_write_r;
    logic              mem_to_reg_r;
    logic [4:0]        wb_addr_r;
    logic [DATA_W-1:0] wb_data_r;

    // Upstream hold; must react in the accepting cycle, so it is decoded from state and request.
    always_comb begin
        stall_s = 1'b0;
        if (!rst_n) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    stall_s = req_valid_i & (~mem_read_n_i | ~mem_write_n_i);
                ISSUE:   stall_s = ~req_store_r;
                WAIT:    stall_s = (cnt_r != {CNT_W{1'b0}});
                default: stall_s = 1'b0;
            endcase
        end
    end

    // Access FSM, latency counter, registered SRAM strobes and MEM/WB bundle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            req_addr_r   <= 32'h0000_0000;
            req_ctrl_r   <= '{reg_write: 1'b0, mem_to_reg: 1'b0, wb_addr: 5'd0};
            req_store_r  <= 1'b0;
            sram_cs_n_r  <= 1'b1;
            sram_we_n_r  <= 1'b1;
            sram_addr_r  <= {ADDR_W{1'b0}};
            sram_wdata_r <= {DATA_W{1'b0}};
            wb_valid_r   <= 1'b0;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            wb_addr_r    <= 5'd0;
            wb_data_r    <= {DATA_W{1'b0}};
        end else begin
            sram_cs_n_r <= 1'b1;
            sram_we_n_r <= 1'b1;
            wb_valid_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid_i) begin
                        req_addr_r  <= addr_i;
                        req_ctrl_r  <= '{reg_write: reg_write_i, mem_to_reg: mem_to_reg_i,
                                         wb_addr: wb_addr_i};
                        req_store_r <= ~mem_write_n_i;
                        if (!mem_write_n_i || !mem_read_n_i) begin
                            state_r     <= ISSUE;
                            sram_cs_n_r <= 1'b0;
                            sram_we_n_r <= mem_write_n_i;
                            sram_addr_r <= addr_i[ADDR_W+1:2];
                            if (!mem_write_n_i) begin
                                sram_wdata_r <= wdata_i;
                            end
                        end else begin
                            wb_valid_r   <= 1'b1;
                            reg_write_r  <= reg_write_i;
                            mem_to_reg_r <= mem_to_reg_i;
                            wb_addr_r    <= wb_addr_i;
                            wb_data_r    <= DATA_W'(addr_i);
                        end
                    end
                end
                ISSUE: begin
                    if (req_store_r) begin
                        state_r      <= IDLE;
                        wb_valid_r   <= 1'b1;
                        reg_write_r  <= req_ctrl_r.reg_write;
                        mem_to_reg_r <= req_ctrl_r.mem_to_reg;
                        wb_addr_r    <= req_ctrl_r.wb_addr;
                        wb_data_r    <= DATA_W'(req_addr_r);
                    end else begin
                        state_r <= WAIT;
                        cnt_r   <= CNT_W'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    // Count reaches zero in the cycle the read data is valid.
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r      <= IDLE;
                        wb_valid_r   <= 1'b1;
                        reg_write_r  <= req_ctrl_r.reg_write;
                        mem_to_reg_r <= req_ctrl_r.mem_to_reg;
                        wb_addr_r    <= req_ctrl_r.wb_addr;
                        wb_data_r    <= sram_rdata_i;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign stall_o      = stall_s;
    assign sram_cs_n_o  = sram_cs_n_r;
    assign sram_we_n_o  = sram_we_n_r;
    assign sram_addr_o  = sram_addr_r;
    assign sram_wdata_o = sram_wdata_r;
    assign wb_valid_o   = wb_valid_r;
    assign reg_write_o  = reg_write_r;
    assign mem_to_reg_o = mem_to_reg_r;
    assign wb_addr_o    = wb_addr_r;
    assign wb_data_o    = wb_data_r;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: two instances (RD_LAT=2 and RD_LAT=1), each with
// its own SRAM model; writebacks are checked against a scoreboard queue.
module tb_mem_stage_access;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  wba;
        logic        rw;
        logic        m2r;
    } exp_t;

    typedef struct {
        logic        rd_n;
        logic        wr_n;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wba;
        logic        rw;
        logic        m2r;
        int          exp_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, rd_n, wr_n, rw, m2r;
    logic [31:0] addr, wdata;
    logic [4:0]  wba;

    logic              stall [2];
    logic              cs_n [2];
    logic              we_n [2];
    logic [ADDR_W-1:0] s_addr [2];
    logic [31:0]       s_wdata [2];
    logic [31:0]       s_rdata [2];
    logic              wbv [2];
    logic              o_rw [2];
    logic              o_m2r [2];
    logic [4:0]        o_wba [2];
    logic [31:0]       o_data [2];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          sel = 0;
    exp_t        sb_q [$];
    int          wb_cyc_q [$];
    exp_t        exp_e;
    logic [31:0] ref_mem [DEPTH];
    vec_t        vecs [8];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 ^ 32'(i);
        if (i == 4)  w = 32'h1234_5678;
        if (i == 16) w = 32'hCAFE_F00D;
        return w;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : 1;
        logic [31:0]       mem [DEPTH];
        logic [31:0]       pipe [LAT];
        int                cs_cnt = 0;
        int                last_cs_cyc = -1;
        logic              last_we_n = 1'b1;
        logic [ADDR_W-1:0] last_addr = '0;
        logic [31:0]       last_wdata = 32'h0;

        mem_stage_access #(.RD_LAT(LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
            .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid),
            .mem_read_n_i(rd_n), .mem_write_n_i(wr_n), .addr_i(addr), .wdata_i(wdata),
            .reg_write_i(rw), .mem_to_reg_i(m2r), .wb_addr_i(wba),
            .stall_o(stall[g]), .sram_cs_n_o(cs_n[g]), .sram_we_n_o(we_n[g]),
            .sram_addr_o(s_addr[g]), .sram_wdata_o(s_wdata[g]), .sram_rdata_i(s_rdata[g]),
            .wb_valid_o(wbv[g]), .reg_write_o(o_rw[g]), .mem_to_reg_o(o_m2r[g]),
            .wb_addr_o(o_wba[g]), .wb_data_o(o_data[g])
        );

        assign s_rdata[g] = pipe[LAT-1];

        initial for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);

        // Read data appears LAT cycles after the chip-select cycle; junk otherwise.
        always @(posedge clk) begin
            if (!cs_n[g] && !we_n[g]) mem[s_addr[g]] <= s_wdata[g];
            pipe[0] <= (!cs_n[g] && we_n[g]) ? mem[s_addr[g]] : JUNK;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        always @(negedge clk) begin
            if (!cs_n[g]) begin
                cs_cnt      <= cs_cnt + 1;
                last_cs_cyc <= cyc;
                last_we_n   <= we_n[g];
                last_addr   <= s_addr[g];
                last_wdata  <= s_wdata[g];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request, push its expected writeback, return once accepted.
    task automatic send(input logic r_n, input logic w_n, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] wa, input logic w,
                        input logic m, output int n_stall, output int t0);
        exp_t e2;
        logic s;
        t0 = cyc;
        req_valid = 1'b1; rd_n = r_n; wr_n = w_n; addr = a; wdata = d;
        wba = wa; rw = w; m2r = m;
        e2.wba = wa; e2.rw = w; e2.m2r = m;
        if (!w_n) begin
            ref_mem[a[ADDR_W+1:2]] = d;
            e2.data = a;
        end else if (!r_n) begin
            e2.data = ref_mem[a[ADDR_W+1:2]];
        end else begin
            e2.data = a;
        end
        sb_q.push_back(e2);
        n_stall = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s = stall[sel];
            @(posedge clk);
            #1;
            if (!s) break;
            n_stall++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, t0, t1, cs0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        vecs[0] = '{1'b1, 1'b1, 32'h0000_00FF, 32'h0,         5'd1,  1'b1, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0104, 32'hA1B2_C3D4, 5'd0,  1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0,         5'd2,  1'b1, 1'b1, 3};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_F104, 32'h0,         5'd3,  1'b1, 1'b1, 3};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0203, 32'h0F0F_0F0F, 5'd6,  1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0200, 32'h0,         5'd4,  1'b1, 1'b1, 3};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0,         5'd31, 1'b1, 1'b1, 3};
        vecs[7] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,         5'd0,  1'b0, 1'b0, 0};

        rst_n = 1'b0; req_valid = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        addr = 32'h0; wdata = 32'h0; wba = 5'd0; rw = 1'b0; m2r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_cs_n", 64'(cs_n[g]), 64'd1);
            check("rst_we_n", 64'(we_n[g]), 64'd1);
            check("rst_stall", 64'(stall[g]), 64'd0);
            check("rst_wb_valid", 64'(wbv[g]), 64'd0);
            check("rst_outputs", {27'd0, o_rw[g], o_m2r[g], o_wba[g], o_data[g]}, 64'd0);
            check("rst_sram_bus", {22'd0, s_addr[g], s_wdata[g]}, 64'd0);
        end
        rst_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && wbv[sel]) begin
                    wb_cyc_q.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected: got data=%h wb_addr=%0d, expected no writeback",
                                 o_data[sel], o_wba[sel]);
                    end else begin
                        exp_e = sb_q.pop_front();
                        check("wb_bundle", {25'd0, o_data[sel], o_wba[sel], o_rw[sel], o_m2r[sel]},
                              {25'd0, exp_e.data, exp_e.wba, exp_e.rw, exp_e.m2r});
                    end
                end
            end
        join_none
        idle(2);

        // Load, RD_LAT=2: three stall cycles, writeback in cycle 4.
        wb_cyc_q.delete();
        send(1'b0, 1'b1, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1, n, t0);
        check("load_stall_cycles", 64'(n), 64'd3);
        idle(4);
        check("load_wb_cycle", 64'((wb_cyc_q.size() > 0) ? wb_cyc_q[0] : -1), 64'(t0 + 4));
        check("load_cs_cycle", 64'(g_dut[0].last_cs_cyc), 64'(t0 + 1));
        check("load_we_n", 64'(g_dut[0].last_we_n), 64'd1);

        // Store: one stall cycle, SRAM write in cycle 1, writeback in cycle 2.
        wb_cyc_q.delete();
        send(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0, n, t0);
        check("store_stall_cycles", 64'(n), 64'd1);
        idle(3);
        check("store_cs_cycle", 64'(g_dut[0].last_cs_cyc), 64'(t0 + 1));
        check("store_we_n", 64'(g_dut[0].last_we_n), 64'd0);
        check("store_sram_addr", 64'(g_dut[0].last_addr), 64'd4);
        check("store_sram_wdata", 64'(g_dut[0].last_wdata), 64'hDEAD_BEEF);
        check("store_wb_cycle", 64'((wb_cyc_q.size() > 0) ? wb_cyc_q[0] : -1), 64'(t0 + 2));

        // Three back-to-back ALU ops: no stall, consecutive pulses.
        wb_cyc_q.delete();
        t1 = cyc;
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, 1'b1, 32'(i), 32'h0, 5'(i + 8), 1'b1, 1'b0, n, t0);
            check("alu_stall_cycles", 64'(n), 64'd0);
        end
        idle(3);
        check("alu_wb_count", 64'(wb_cyc_q.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check("alu_wb_cycle", 64'((wb_cyc_q.size() > i) ? wb_cyc_q[i] : -1), 64'(t1 + 1 + i));

        // Mixed load/store/ALU stream with no gaps.
        wb_cyc_q.delete();
        cs0 = g_dut[0].cs_cnt;
        send(1'b0, 1'b1, 32'h10, 32'h0, 5'd12, 1'b1, 1'b1, n, t0);
        send(1'b1, 1'b0, 32'h44, 32'h55AA_55AA, 5'd13, 1'b0, 1'b0, n, t0);
        send(1'b1, 1'b1, 32'h77, 32'h0, 5'd14, 1'b1, 1'b0, n, t0);
        idle(6);
        check("mixed_cs_pulses", 64'(g_dut[0].cs_cnt - cs0), 64'd2);
        check("mixed_wb_count", 64'(wb_cyc_q.size()), 64'd3);
        check("mixed_sb_drained", 64'(sb_q.size()), 64'd0);

        // Both strobes low behaves as a store; read-back confirms the write.
        send(1'b0, 1'b0, 32'h20, 32'h1357_9BDF, 5'd15, 1'b1, 1'b0, n, t0);
        check("both_low_stall_cycles", 64'(n), 64'd1);
        idle(2);
        check("both_low_we_n", 64'(g_dut[0].last_we_n), 64'd0);
        check("both_low_sram_addr", 64'(g_dut[0].last_addr), 64'd8);
        send(1'b0, 1'b1, 32'h20, 32'h0, 5'd16, 1'b1, 1'b1, n, t0);
        idle(4);

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].rd_n, vecs[v].wr_n, vecs[v].addr, vecs[v].wdata, vecs[v].wba,
                 vecs[v].rw, vecs[v].m2r, n, t0);
            check("table_stall_cycles", 64'(n), 64'(vecs[v].exp_stall));
        end
        idle(6);
        check("table_sb_drained", 64'(sb_q.size()), 64'd0);

        // Reset while the load is in WAIT: no strobe and no writeback afterwards.
        wb_cyc_q.delete();
        cs0 = g_dut[0].cs_cnt;
        req_valid = 1'b1; rd_n = 1'b0; wr_n = 1'b1; addr = 32'h40; wba = 5'd9; rw = 1'b1; m2r = 1'b1;
        @(posedge clk); #1;
        idle(1);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_cs_n", 64'(cs_n[0]), 64'd1);
            check("midrst_we_n", 64'(we_n[0]), 64'd1);
            check("midrst_stall", 64'(stall[0]), 64'd0);
            check("midrst_wb_valid", 64'(wbv[0]), 64'd0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        idle(6);
        check("midrst_no_wb", 64'(wb_cyc_q.size()), 64'd0);
        check("midrst_cs_pulses", 64'(g_dut[0].cs_cnt - cs0), 64'd1);

        // RD_LAT=1 instance: two stall cycles, writeback in cycle 3.
        sel = 1;
        wb_cyc_q.delete();
        send(1'b0, 1'b1, 32'h40, 32'h0, 5'd5, 1'b1, 1'b1, n, t0);
        check("lat1_stall_cycles", 64'(n), 64'd2);
        idle(4);
        check("lat1_wb_cycle", 64'((wb_cyc_q.size() > 0) ? wb_cyc_q[0] : -1), 64'(t0 + 3));
        check("final_sb_drained", 64'(sb_q.size()), 64'd0);
        sel = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
